// File: rtl/simple_circuit_pkg.sv
// Shared constants for the simple_circuit block: default counter width and
// the reference truth table of f(A,B,C), indexed by {A,B,C}.
package simple_circuit_pkg;

    localparam int CNT_W_DEFAULT = 8;
    localparam int NUM_COMBOS    = 8;

    // f = 1 for minterms 1, 5, 6, 7
    localparam logic [NUM_COMBOS-1:0] TRUTH_TABLE = 8'b1110_0010;

    function automatic logic [2:0] abc_index(input logic a, input logic b, input logic c);
        return {a, b, c};
    endfunction

endpackage

// File: rtl/simple_circuit_core.sv
// Pure combinational logic function f = (A & B) | (~B & C).
module simple_circuit_core (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic f
);

    logic w1;
    logic w2;
    logic w3;

    assign w1 = A & B;
    assign w2 = ~B & C;
    assign w3 = w1 | w2;
    assign f  = w3;

endmodule

// File: rtl/simple_circuit.sv
// Registered logic result plus running statistics: a saturating ones counter
// and a mask of which {A,B,C} combinations have been accepted.
module simple_circuit
    import simple_circuit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  A,
    input  logic                  B,
    input  logic                  C,
    input  logic                  in_valid,
    input  logic                  clr,
    output logic                  Z,
    output logic                  out_valid,
    output logic [CNT_W-1:0]      ones_cnt,
    output logic [NUM_COMBOS-1:0] seen_mask,
    output logic                  all_seen
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                  f;
    logic [2:0]            sample_idx;

    logic                  z_reg;
    logic                  z_next;
    logic                  out_valid_reg;
    logic                  out_valid_next;
    logic [CNT_W-1:0]      ones_cnt_reg;
    logic [CNT_W-1:0]      ones_cnt_next;
    logic [NUM_COMBOS-1:0] seen_mask_reg;
    logic [NUM_COMBOS-1:0] seen_mask_next;

    simple_circuit_core u_core (
        .A (A),
        .B (B),
        .C (C),
        .f (f)
    );

    assign sample_idx = abc_index(A, B, C);

    // Z holds when no sample is offered, so operand values are don't-care then.
    always_comb begin
        z_next         = z_reg;
        out_valid_next = 1'b0;
        if (in_valid) begin
            z_next         = f;
            out_valid_next = 1'b1;
        end
    end

    // Clear wins over a same-cycle sample; the counter sticks at its maximum.
    always_comb begin
        ones_cnt_next = ones_cnt_reg;
        if (clr) begin
            ones_cnt_next = '0;
        end else if (in_valid && f && (ones_cnt_reg != CNT_MAX)) begin
            ones_cnt_next = ones_cnt_reg + CNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COMBOS; gi++) begin : g_seen
            assign seen_mask_next[gi] = clr ? 1'b0
                                      : (seen_mask_reg[gi] | (in_valid && (sample_idx == 3'(gi))));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_reg         <= 1'b0;
            out_valid_reg <= 1'b0;
            ones_cnt_reg  <= '0;
            seen_mask_reg <= '0;
        end else begin
            z_reg         <= z_next;
            out_valid_reg <= out_valid_next;
            ones_cnt_reg  <= ones_cnt_next;
            seen_mask_reg <= seen_mask_next;
        end
    end

    assign Z         = z_reg;
    assign out_valid = out_valid_reg;
    assign ones_cnt  = ones_cnt_reg;
    assign seen_mask = seen_mask_reg;
    assign all_seen  = &seen_mask_reg;

endmodule

// File: tb/tb_simple_circuit.sv
// Randomized self-checking bench for simple_circuit against a truth-table model;
// a second instance with CNT_W=2 exercises counter saturation in parallel.
module tb_simple_circuit;

    logic       clk;
    logic       rst_n;
    logic       A;
    logic       B;
    logic       C;
    logic       in_valid;
    logic       clr;

    logic       z8;
    logic       ov8;
    logic [7:0] cnt8;
    logic [7:0] mask8;
    logic       all8;

    logic       z2;
    logic       ov2;
    logic [1:0] cnt2;
    logic [7:0] mask2;
    logic       all2;

    int n_checks;
    int n_fail;

    // Reference model state
    int tt [8] = '{0, 1, 0, 0, 0, 1, 1, 1};
    int m_z;
    int m_ov;
    int m_cnt8;
    int m_cnt2;
    int m_mask;

    simple_circuit #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .C         (C),
        .in_valid  (in_valid),
        .clr       (clr),
        .Z         (z8),
        .out_valid (ov8),
        .ones_cnt  (cnt8),
        .seen_mask (mask8),
        .all_seen  (all8)
    );

    simple_circuit #(.CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .C         (C),
        .in_valid  (in_valid),
        .clr       (clr),
        .Z         (z2),
        .out_valid (ov2),
        .ones_cnt  (cnt2),
        .seen_mask (mask2),
        .all_seen  (all2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare everything.
    task automatic step(input int rst, input int clr_i, input int iv, input int abc);
        int idx;
        rst_n    = (rst == 0);
        clr      = clr_i[0];
        in_valid = iv[0];
        A        = abc[2];
        B        = abc[1];
        C        = abc[0];
        idx      = abc & 7;
        @(posedge clk);
        if (rst != 0) begin
            m_z = 0; m_ov = 0; m_cnt8 = 0; m_cnt2 = 0; m_mask = 0;
        end else begin
            if (iv != 0) begin
                m_z  = tt[idx];
                m_ov = 1;
            end else begin
                m_ov = 0;
            end
            if (clr_i != 0) begin
                m_cnt8 = 0; m_cnt2 = 0; m_mask = 0;
            end else if (iv != 0) begin
                if (tt[idx] == 1) begin
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3)   m_cnt2++;
                end
                m_mask = m_mask | (1 << idx);
            end
        end
        #1;
        $display("txn rst=%0d clr=%0d iv=%0d abc=%0d%0d%0d -> Z=%0d ov=%0d cnt=%0d cnt2=%0d mask=%02h all=%0d",
                 rst, clr_i, iv, abc[2], abc[1], abc[0], z8, ov8, cnt8, cnt2, mask8, all8);
        if (m_ov == 1) check("z", int'(z8), m_z);
        else           check("z_hold", int'(z8), m_z);
        check("out_valid", int'(ov8), m_ov);
        check("ones_cnt", int'(cnt8), m_cnt8);
        check("seen_mask", int'(mask8), m_mask);
        check("all_seen", int'(all8), (m_mask == 255) ? 1 : 0);
        check("z_sat", int'(z2), m_z);
        check("ones_cnt_sat", int'(cnt2), m_cnt2);
        check("seen_mask_sat", int'(mask2), m_mask);
        check("all_seen_sat", int'(all2), (m_mask == 255) ? 1 : 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_z = 0; m_ov = 0; m_cnt8 = 0; m_cnt2 = 0; m_mask = 0;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; A = 1'b0; B = 1'b0; C = 1'b0;

        // Reset, with a valid sample offered that must be discarded
        step(1, 0, 1, 7);
        step(1, 0, 0, 0);

        // Exhaustive sweep
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, i);
            check("sweep_z", int'(z8), tt[i]);
        end
        check("sweep_cnt", int'(cnt8), 4);
        check("sweep_mask", int'(mask8), 255);
        check("sweep_all_seen", int'(all8), 1);

        // Hold after ABC=101
        step(0, 0, 1, 5);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, int'($urandom_range(0, 7)));
            check("hold_z", int'(z8), 1);
            check("hold_ov", int'(ov8), 0);
        end

        // Clear, then saturation on the 2-bit instance
        step(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 7);
        check("sat_cnt2", int'(cnt2), 3);
        check("sat_cnt8", int'(cnt8), 6);

        // Clear collides with a valid sample
        step(0, 1, 1, 1);
        check("clr_z", int'(z8), 1);
        check("clr_cnt", int'(cnt8), 0);
        check("clr_mask", int'(mask8), 0);

        // Reset mid-sweep at ABC=110, then resume
        for (int i = 0; i < 6; i++) step(0, 0, 1, i);
        step(1, 0, 1, 6);
        check("rst_z", int'(z8), 0);
        check("rst_cnt", int'(cnt8), 0);
        step(0, 0, 1, 6);
        step(0, 0, 1, 7);
        check("resume_cnt", int'(cnt8), 2);
        check("resume_mask", int'(mask8), 8'hC0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0) ? 1 : 0,
                 ($urandom_range(0, 15) == 0) ? 1 : 0,
                 int'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_circuit.md
SIMPLE_CIRCUIT -- requirements
Module: simple_circuit

Interface
REQ-001 Parameter CNT_W, default 8, width of the ones counter in bits; legal range 2..16.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port A  input  1  logic operand A.
REQ-005 Port B  input  1  logic operand B.
REQ-006 Port C  input  1  logic operand C.
REQ-007 Port in_valid  input  1  operands A/B/C are valid this cycle.
REQ-008 Port clr  input  1  synchronous clear of the statistics (ones_cnt, seen_mask).
REQ-009 Port Z  output  1  registered logic result.
REQ-010 Port out_valid  output  1  Z was updated on the last rising edge.
REQ-011 Port ones_cnt  output  CNT_W  saturating count of accepted samples with result 1.
REQ-012 Port seen_mask  output  8  bit {A,B,C} is set once that input combination has been accepted.
REQ-013 Port all_seen  output  1  all 8 input combinations have been accepted since the last reset or clear.

Function
REQ-014 The logic function SHALL be f = (A AND B) OR (NOT B AND C), built from internal nets w1 = A AND B, w2 = NOT B AND C, and w3 = w1 OR w2.
REQ-015 Truth table for ABC = 000..111 SHALL be f = 0,1,0,0,0,1,1,1 (f = 1 for minterms 1, 5, 6, 7).
REQ-016 When in_valid=1 at a rising edge: Z <= f(A,B,C) and out_valid <= 1; latency is exactly one cycle.
REQ-017 When in_valid=0 at a rising edge: Z holds its value and out_valid <= 0.
REQ-018 When in_valid=1 and f=1: ones_cnt SHALL increment by 1 and saturate at 2^CNT_W-1; it never wraps.
REQ-019 When in_valid=1: seen_mask[{A,B,C}] <= 1; already-set bits remain set.
REQ-020 all_seen SHALL equal the AND of all 8 bits of the seen_mask register, with no added latency beyond seen_mask.
REQ-021 When clr=1: ones_cnt <= 0 and seen_mask <= 0; Z and out_valid SHALL still update per REQ-016/017.
REQ-022 When clr=1 and in_valid=1 in the same cycle: clr wins for the statistics, so that cycle's sample is not counted or recorded.
REQ-023 X/Z values on A/B/C while in_valid=0 SHALL NOT affect any state.

Reset
REQ-024 When rst_n=0 at a rising edge: Z=0, out_valid=0, ones_cnt=0, seen_mask=0, all_seen=0.
REQ-025 Reset SHALL take priority over in_valid and clr.
REQ-026 Reset asserted mid-stream SHALL discard the sample presented in that cycle.
REQ-027 The first sample SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-028 A shared package simple_circuit_pkg SHALL hold the default CNT_W and the 8-bit truth-table constant 8'b1110_0010, indexed by {A,B,C}.
REQ-029 The pure combinational function SHALL live in one sub-module, simple_circuit_core (inputs A, B, C; output f).
REQ-030 All registers (Z, out_valid, ones_cnt, seen_mask) SHALL be in the top-level simple_circuit.

Verification
REQ-031 Exhaustive sweep: apply ABC = 000..111, one per cycle with in_valid=1 -> Z sequence one cycle later is 0,1,0,0,0,1,1,1; ones_cnt=4; seen_mask=8'hFF; all_seen=1.
REQ-032 Hold: set in_valid=0 for 5 cycles after ABC=101 -> Z stays 1, out_valid=0, ones_cnt unchanged.
REQ-033 Saturation with CNT_W=2: apply ABC=111 for 6 cycles -> ones_cnt reaches 3 and stays 3.
REQ-034 Clear collision: assert clr=1 and in_valid=1 with ABC=001 -> Z=1 next cycle, ones_cnt=0, seen_mask=0.
REQ-035 Reset mid-sweep: assert rst_n=0 during ABC=110 -> next cycle all outputs are 0; resume the sweep -> counts restart from 0.
REQ-036 Self-checking bench SHALL compare Z against a reference model of REQ-014 on every cycle with out_valid=1.
